// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch-stage sequencer.
// Provides the FSM state encoding used by fetch_ctrl and by anything monitoring its state.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StDrain  = 2'd2,
    StHalted = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the fetch-stage perf counters.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset, clears the count
//   inc    increment request for this cycle
//   cnt    current count, holds at all-ones once saturated
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: arbitrates EX redirects, ID load-use stalls and ID halt decode,
// drives the fetch stage controls and pipeline flushes, and sequences boot and halt drain.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   br_taken, br_target    EX redirect request and target
//   ld_use_haz             ID load-use hazard
//   hlt_dec                ID decoded a valid HLT
//   stall, alt_pc_ctrl,
//   alt_pc, hlt            fetch-stage controls (combinational, act at next edge)
//   flush_if_id,
//   flush_id_ex            pipeline register squash/bubble
//   halted                 sticky, pipeline fully drained after HLT
//   stall_cnt, redir_cnt   saturating perf counters
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BOOT_CYC  = 1,
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              ld_use_haz,
  input  logic              hlt_dec,
  output logic              stall,
  output logic              alt_pc_ctrl,
  output logic [ADDR_W-1:0] alt_pc,
  output logic              hlt,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  redir_cnt
);

  localparam int unsigned BootW  = (BOOT_CYC > 1) ? $clog2(BOOT_CYC + 1) : 1;
  localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

  fetch_state_e      state_q, state_d;
  logic [BootW-1:0]  boot_cnt_q, boot_cnt_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic              halted_q;
  logic              stall_inc, redir_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      boot_cnt_q  <= BootW'(BOOT_CYC);
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      if (state_d == StHalted) begin
        halted_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    drain_cnt_d = drain_cnt_q;
    stall       = 1'b0;
    alt_pc_ctrl = 1'b0;
    alt_pc      = '0;
    hlt         = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    stall_inc   = 1'b0;
    redir_inc   = 1'b0;

    case (state_q)
      StBoot: begin
        stall       = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (boot_cnt_q != '0) begin
          boot_cnt_d = boot_cnt_q - 1'b1;
        end
        // Leave on the cycle the count expires so BOOT lasts exactly BOOT_CYC cycles.
        if (boot_cnt_q <= BootW'(1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (br_taken) begin
          // Younger hlt_dec / ld_use_haz are flushed along with the wrong path.
          alt_pc_ctrl = 1'b1;
          alt_pc      = br_target;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          redir_inc   = 1'b1;
        end else if (hlt_dec) begin
          // The HLT itself flows on to WB; only the fetch behind it is squashed.
          hlt         = 1'b1;
          flush_if_id = 1'b1;
          state_d     = StDrain;
          drain_cnt_d = DrainW'(DRAIN_CYC - 1);
        end else if (ld_use_haz) begin
          stall       = 1'b1;
          flush_id_ex = 1'b1;
          stall_inc   = 1'b1;
        end
      end
      StDrain: begin
        if (br_taken) begin
          // An older branch resolved behind us: the HLT was on the wrong path.
          alt_pc_ctrl = 1'b1;
          alt_pc      = br_target;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          redir_inc   = 1'b1;
          state_d     = StRun;
          drain_cnt_d = '0;
        end else begin
          hlt         = 1'b1;
          flush_if_id = 1'b1;
          if (drain_cnt_q == '0) begin
            state_d = StHalted;
          end else begin
            drain_cnt_d = drain_cnt_q - 1'b1;
          end
        end
      end
      StHalted: begin
        hlt   = 1'b1;
        stall = 1'b1;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  assign halted = halted_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_inc),
    .cnt  (stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_redir_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (redir_inc),
    .cnt  (redir_cnt)
  );

endmodule
